// File: rtl/same_bit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : same_bit_pipe
// Description : DEPTH-stage elastic register pipeline with valid/ready
//               handshaking on both sides. Each stage holds one WIDTH-bit word
//               plus a valid bit; a stage advances whenever its successor
//               advances or is empty, so bubbles collapse and full throughput
//               is kept under back-pressure. flush drops every word in flight.
//
// Ports       : clk         - clock, all state updates on the rising edge
//               reset       - synchronous active-high reset (clears data+valid)
//               flush       - drop all words in flight at the next edge
//               Ain         - input word
//               Ain_valid   - Ain offered for transfer
//               Ain_ready   - pipeline accepts Ain this cycle
//               Aout        - output word (last stage data register)
//               Aout_valid  - Aout holds a word (last stage valid bit)
//               Aout_ready  - consumer takes Aout this cycle
//               occupancy   - number of valid stages (only with
//                             SAME_BIT_PIPE_COUNT_EN defined)
//
// Options     : SAME_BIT_PIPE_COUNT_EN - adds the registered occupancy port
//
// Revision    : 1.0 - initial release
// ============================================================================
module same_bit_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             Ain,
    input  logic                         Ain_valid,
    output logic                         Ain_ready,
    output logic [WIDTH-1:0]             Aout,
    output logic                         Aout_valid,
    input  logic                         Aout_ready
`ifdef SAME_BIT_PIPE_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`endif
);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_valid_nxt;
    logic             w_in_fire;

    // Stage k advances when the consumer is ready or any stage downstream of
    // it (including the last stage itself for k = DEPTH-1) is empty. This is
    // the unrolled form of the ripple "advance[k+1] || !valid[k+1]", written
    // without a self-referencing vector so there is no combinational loop.
    always_comb begin
        w_adv = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_adv[k] = Aout_ready;
            for (int j = k; j < DEPTH; j++) begin
                if ((j > k || k == DEPTH - 1) && !r_valid[j]) begin
                    w_adv[k] = 1'b1;
                end
            end
        end
    end

    // No path from Ain_valid; reset and flush block acceptance.
    assign Ain_ready = w_adv[0] && !flush && !reset;
    assign w_in_fire = Ain_valid && Ain_ready;

    always_comb begin
        w_valid_nxt    = r_valid;
        w_valid_nxt[0] = w_adv[0] ? w_in_fire : r_valid[0];
        for (int k = 1; k < DEPTH; k++) begin
            w_valid_nxt[k] = w_adv[k] ? r_valid[k-1] : r_valid[k];
        end
        if (flush) begin
            w_valid_nxt = '0;
        end
    end

    // Data registers load only when real data moves in, so an empty pipeline
    // keeps Aout stable and flush leaves the (invalid) data untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            if (w_in_fire) begin
                r_data[0] <= Ain;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_adv[k] && r_valid[k-1] && !flush) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    assign Aout       = r_data[DEPTH-1];
    assign Aout_valid = r_valid[DEPTH-1];

`ifdef SAME_BIT_PIPE_COUNT_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] r_occupancy;
    logic [OCC_W-1:0] w_occ_nxt;

    // Count the valid bits that will be present after this edge so the
    // registered count always matches the registered valid vector.
    always_comb begin
        w_occ_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occupancy <= '0;
        end else begin
            r_occupancy <= w_occ_nxt;
        end
    end

    assign occupancy = r_occupancy;
`endif

endmodule
`default_nettype wire

// File: doc/same_bit_pipe.md
SAME_BIT_PIPE -- requirements
Module: same_bit_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per word (WIDTH >= 1) SHALL be supported.
REQ-002 Parameter DEPTH, default 4, number of register stages (DEPTH >= 1) SHALL be supported.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all words in flight.
REQ-006 Ain  input  WIDTH  input word.
REQ-007 Ain_valid  input  1  Ain holds a word offered for transfer.
REQ-008 Ain_ready  output  1  pipeline accepts Ain this cycle.
REQ-009 Aout  output  WIDTH  output word, equal to Ain of the corresponding accepted transfer.
REQ-010 Aout_valid  output  1  Aout holds a word.
REQ-011 Aout_ready  input  1  consumer takes Aout this cycle.

Function
REQ-012 Stages 0..DEPTH-1 SHALL each hold a WIDTH-bit data register and a valid bit; Aout/Aout_valid SHALL be stage DEPTH-1 data/valid, driven directly from registers.
REQ-013 Input transfer occurs when Ain_valid && Ain_ready; output transfer occurs when Aout_valid && Aout_ready.
REQ-014 Stage DEPTH-1 advances when Aout_ready or !valid[DEPTH-1]; stage k < DEPTH-1 advances when stage k+1 advances or !valid[k+1].
REQ-015 Ain_ready SHALL equal "stage 0 advances" (combinational path from Aout_ready permitted; no path from Ain_valid to Ain_ready).
REQ-016 An advancing stage SHALL load the data/valid of its predecessor (stage 0 loads Ain, Ain_valid && Ain_ready); a non-advancing stage SHALL hold data and valid unchanged.
REQ-017 Unstalled latency SHALL be exactly DEPTH cycles from input transfer to Aout_valid; throughput SHALL be one word per cycle.
REQ-018 Words SHALL emerge in acceptance order, bit-exact, with no loss or duplication.
REQ-019 Full (all valid, Aout_ready=0): Ain_ready SHALL be 0 and all stages SHALL hold.
REQ-020 Full with Aout_ready=1: output transfer and input transfer SHALL occur in the same cycle.
REQ-021 Empty: Aout_valid SHALL be 0; Aout value is don't-care but SHALL be stable.
REQ-022 flush=1 SHALL clear every valid bit at the next edge, SHALL take priority over input and output transfer, and Ain_ready SHALL be 0 while flush=1.
REQ-023 Data registers of invalid stages SHALL NOT affect any output other than Aout.

Reset
REQ-024 reset=1 at a rising edge SHALL clear all valid bits and all data registers to 0; Aout=0, Aout_valid=0.
REQ-025 Ain_ready SHALL be 0 while reset=1; reset SHALL take priority over flush and all transfers.
REQ-026 Reset asserted mid-stream SHALL discard all words in flight; the first post-reset input transfer SHALL emerge after exactly DEPTH cycles.

Configuration
REQ-027 Macro SAME_BIT_PIPE_COUNT_EN, when defined, SHALL add output port occupancy, width $clog2(DEPTH+1), equal to the number of stages with valid=1, registered, reset to 0, cleared by flush.
REQ-028 With SAME_BIT_PIPE_COUNT_EN undefined, the occupancy port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 WIDTH=8, DEPTH=4, Aout_ready=1, Ain=8'hA5 valid one cycle -> Aout=8'hA5, Aout_valid=1 exactly 4 cycles later, for one cycle.
REQ-030 Stream 8'h01..8'h08 back-to-back, Aout_ready=1 -> 8'h01..8'h08 emerge on consecutive cycles from cycle 4.
REQ-031 Aout_ready=0, offer 8'h10..8'h15 -> 4 accepted (8'h10..8'h13), Ain_ready=0 thereafter; Aout_ready=1 -> 8'h10..8'h15 in order, no gaps after first.
REQ-032 Pipeline full, flush=1 one cycle -> next cycle Aout_valid=0, (occupancy=0 with SAME_BIT_PIPE_COUNT_EN); next word 8'h77 emerges 4 cycles after acceptance.
REQ-033 Words in flight, reset=1 one cycle -> Aout=0, Aout_valid=0, Ain_ready=0 during reset; no pre-reset word ever emerges.
REQ-034 WIDTH=1, DEPTH=1, Ain alternating 0,1 with Aout_ready=1 -> Aout equals Ain delayed one cycle; Aout_ready=0 with stage full -> Ain_ready=0.
